// File: rtl/seq_mul32.sv
// seq_mul32: sequential 32x32 unsigned shift-add multiplier with a start/busy/done
// handshake, plus the 32-bit carry-lookahead adder (cla) that it is built around.
//
// seq_mul32 ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset
//   start    in   1   request, accepted in IDLE or DONE
//   a        in  32   multiplicand, captured on acceptance
//   b        in  32   multiplier, captured on acceptance
//   busy     out  1   high while running
//   done     out  1   one-cycle completion pulse
//   product  out 64   result, held until the next completion
//
// cla ports:
//   o     out 32   sum
//   cout  out  1   carry out
//   a, b  in  32   addends

// 32-bit adder: 4-bit lookahead groups chained through group generate/propagate.
module cla (
  output logic [31:0] o,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries inside each group come straight from the group carry-in.
  always_comb begin
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
               | (p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+4] = (g[4*i+3] | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]))
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
    end
  end

  assign o    = p ^ c[31:0];
  assign cout = c[32];

endmodule

module seq_mul32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  product_q, product_d;

  logic [W-1:0]    add_b;
  logic [W-1:0]    sum_o;
  logic            sum_cout;
  logic [2*W-1:0]  shifted;

  // Add the multiplicand into the upper half only when the current multiplier bit is set.
  assign add_b = lo_q[0] ? mcand_q : '0;

  cla u_cla (
    .o    (sum_o),
    .cout (sum_cout),
    .a    (hi_q),
    .b    (add_b)
  );

  // 65-bit {cout, sum, lo} shifted right by one; the carry lands in hi[31].
  assign shifted = {sum_cout, sum_o, lo_q[W-1:1]};

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hi_d  = shifted[2*W-1:W];
        lo_d  = shifted[W-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul32.sv
// Self-checking bench for seq_mul32: expected products are queued when an operation
// is launched and popped when done is observed.
module tb_seq_mul32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic [63:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  seq_mul32 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start and queue the expected product.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(64'(av) * 64'(bv));
  endtask

  // Wait for done; cycles = edges until done (-1 on timeout).
  task automatic wait_done(input int max_cyc, output int cycles, output int busy_cnt,
                           output int overlap);
    cycles   = -1;
    busy_cnt = busy ? 1 : 0;
    overlap  = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk);
      #1;
      if (busy && done) overlap++;
      if (done) begin
        cycles = n;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic do_mul(input logic [31:0] av, input logic [31:0] bv,
                        output logic [63:0] got, output logic [63:0] e,
                        output int cycles, output int busy_cnt, output int overlap);
    start_op(av, bv);
    wait_done(40, cycles, busy_cnt, overlap);
    got = product;
    pop_exp(e);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product got=%h want=0", product); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_flags got=%b want=00", {busy, done}); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL idle_product got=%h want=0", product); end
  endtask

  task automatic test_basic;
    logic [63:0] got, e;
    int cyc, bc, ov;
    do_mul(32'd24, 32'd56, got, e, cyc, bc, ov);
    checks++; if (got !== 64'd1344) begin errors++; $display("FAIL basic_product got=%0d want=1344", got); end
    checks++; if (got !== e) begin errors++; $display("FAIL basic_scoreboard got=%h want=%h", got, e); end
    checks++; if (cyc !== 32) begin errors++; $display("FAIL basic_latency got=%0d want=32", cyc); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=32", bc); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL basic_busy_done_overlap got=%0d want=0", ov); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b want=0", done); end
    checks++; if (product !== 64'd1344) begin errors++; $display("FAIL product_hold got=%0d want=1344", product); end
  endtask

  task automatic test_carry;
    logic [63:0] got, e;
    int cyc, bc, ov;
    do_mul(32'd245451, 32'd4656556, got, e, cyc, bc, ov);
    checks++; if (got !== 64'd1142956326756) begin errors++; $display("FAIL carry_product got=%0d want=1142956326756", got); end
    checks++; if (got !== e) begin errors++; $display("FAIL carry_scoreboard got=%h want=%h", got, e); end
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, got, e, cyc, bc, ov);
    checks++; if (got !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL max_product got=%h want=fffffffe00000001", got); end
    checks++; if (cyc !== 32) begin errors++; $display("FAIL max_latency got=%0d want=32", cyc); end
    for (int i = 0; i < 4; i++) begin
      do_mul($urandom, $urandom, got, e, cyc, bc, ov);
      checks++; if (got !== e) begin errors++; $display("FAIL random_product[%0d] got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_zero_identity;
    logic [63:0] got, e;
    int cyc, bc, ov;
    do_mul(32'd0, 32'hDEADBEEF, got, e, cyc, bc, ov);
    checks++; if (got !== 64'd0) begin errors++; $display("FAIL zero_product got=%h want=0", got); end
    checks++; if (cyc !== 32) begin errors++; $display("FAIL zero_latency got=%0d want=32", cyc); end
    do_mul(32'd1, 32'hDEADBEEF, got, e, cyc, bc, ov);
    checks++; if (got !== 64'h00000000DEADBEEF) begin errors++; $display("FAIL identity_product got=%h want=00000000deadbeef", got); end
    checks++; if (got !== e) begin errors++; $display("FAIL identity_scoreboard got=%h want=%h", got, e); end
  endtask

  task automatic test_start_in_run;
    logic [63:0] e;
    int cyc, bc, ov;
    start_op(32'd1000, 32'd777);
    repeat (5) @(posedge clk);
    #1;
    a     = 32'h12345678;
    b     = 32'h9ABCDEF0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_start_busy got=%b want=1", busy); end
    wait_done(40, cyc, bc, ov);
    pop_exp(e);
    checks++; if (cyc !== 26) begin errors++; $display("FAIL run_start_latency got=%0d want=26", cyc); end
    checks++; if (product !== e) begin errors++; $display("FAIL run_start_product got=%h want=%h", product, e); end
    @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL run_start_no_restart got=%b want=00", {busy, done}); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    int cyc, bc, ov;
    a     = 32'd65537;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(64'd196611);
    a = 32'hCAFEF00D;
    b = 32'h0BADBEEF;
    wait_done(40, cyc, bc, ov);
    pop_exp(e);
    checks++; if (product !== e) begin errors++; $display("FAIL b2b_first_product got=%h want=%h", product, e); end
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(64'(32'hCAFEF00D) * 64'(32'h0BADBEEF));
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle_bubble got=%b want=1", busy); end
    checks++; if (product !== 64'd196611) begin errors++; $display("FAIL b2b_hold_in_run got=%h want=30003", product); end
    wait_done(40, cyc, bc, ov);
    pop_exp(e);
    checks++; if (cyc + 1 !== 33) begin errors++; $display("FAIL b2b_done_spacing got=%0d want=33", cyc + 1); end
    checks++; if (product !== e) begin errors++; $display("FAIL b2b_second_product got=%h want=%h", product, e); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] got, e;
    int cyc, bc, ov, pulses;
    start_op(32'd99999, 32'd88888);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pop_exp(e);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_flags got=%b want=00", {busy, done}); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL midrst_product got=%h want=0", product); end
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_abandoned got=%0d want=0", pulses); end
    do_mul(32'd123456, 32'd654321, got, e, cyc, bc, ov);
    checks++; if (got !== e) begin errors++; $display("FAIL midrst_fresh_product got=%h want=%h", got, e); end
    checks++; if (cyc !== 32) begin errors++; $display("FAIL midrst_fresh_latency got=%0d want=32", cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero_identity();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
